// File: rtl/trng_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : trng_pkg
//  Description : Shared types and constants for the TRNG conditioner.
//  Revision    : 1.0 - initial release
// ============================================================================
package trng_pkg;

  // Transmit handshake states towards uart_tx
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    DRAIN = 2'd2
  } tx_state_t;

  // Cycles ACK waits for uart_busy before assuming the byte was taken
  localparam int ACK_TIMEOUT = 2;
  // Width of the saturating drop counter
  localparam int DROP_W = 16;

  // Width of a counter that runs 0..n-1 (never narrower than one bit)
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/trng_conditioner_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : trng_conditioner_if
//  Description : send/busy/data handshake between the conditioner and uart_tx.
//  Revision    : 1.0 - initial release
// ============================================================================
interface trng_conditioner_if;
  logic       send;
  logic [7:0] data;
  logic       busy;

  // Conditioner side drives the strobe and byte
  modport master (output send, output data, input busy);
  // Transmitter side reports busy
  modport slave  (input send, input data, output busy);
endinterface
`default_nettype wire

// File: rtl/trng_conditioner_byte_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : byte_fifo
//  Description : Synchronous byte FIFO, first-word-fall-through read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  wire                     clk,
  input  wire                     rst,
  input  wire                     wr_en,
  input  wire  [7:0]              wr_data,
  input  wire                     rd_en,
  output logic [7:0]              rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int c_aw = $clog2(DEPTH);
  localparam int c_lw = c_aw + 1;

  logic [7:0]      r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_lw-1:0] r_level;
  logic            w_wr_ok;
  logic            w_rd_ok;

  // Full/empty come from pre-cycle occupancy, so a write into a full FIFO is lost
  assign full    = (r_level == c_lw'(DEPTH));
  assign empty   = (r_level == '0);
  assign w_wr_ok = wr_en && !full;
  assign w_rd_ok = rd_en && !empty;
  assign rd_data = r_mem[r_rd_ptr];
  assign level   = r_level;

  // Storage array, no reset needed since occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/trng_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : trng_conditioner
//  Description : Synchronise, decimate, health-test and debias the raw TRNG
//                bit, pack it into bytes and feed uart_tx through a FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module trng_conditioner
  import trng_pkg::*;
#(
  parameter int SAMPLE_DIV = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int RCT_CUTOFF = 32
) (
  input  wire                           clk,
  input  wire                           rst,
  input  wire                           en,
  input  wire                           raw_bit,
  trng_conditioner_if.master            uart,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DROP_W-1:0]             drop_cnt,
  output logic                          alarm
);
  localparam int c_div_w = cnt_w(SAMPLE_DIV);
  localparam int c_rct_w = cnt_w(RCT_CUTOFF + 1);
  localparam int c_ack_w = cnt_w(ACK_TIMEOUT);

  logic [1:0]         r_sync;
  logic [c_div_w-1:0] r_div;
  logic               w_div_last;
  logic               w_sample;
  logic               w_bit;
  logic               r_prev;
  logic [c_rct_w-1:0] r_rct_cnt;
  logic [c_rct_w-1:0] w_rct_next;
  logic               r_alarm;
  logic               w_accept;
  logic               r_pair_valid;
  logic               r_pair_bit;
  logic               w_emit;
  logic [6:0]         r_shift;
  logic [2:0]         r_bit_cnt;
  logic               w_byte_done;
  logic [7:0]         w_wr_data;
  logic [DROP_W-1:0]  r_drop;
  logic               w_full;
  logic               w_empty;
  logic               w_rd_en;
  logic [7:0]         w_rd_data;
  logic [7:0]         r_last;
  tx_state_t          r_state;
  tx_state_t          w_state_next;
  logic [c_ack_w-1:0] r_ack_cnt;
  logic [c_ack_w-1:0] w_ack_cnt_next;

  assign w_bit       = r_sync[1];
  assign w_div_last  = (r_div == c_div_w'(SAMPLE_DIV - 1));
  assign w_sample    = en && w_div_last;
  // Once the health test has tripped, samples no longer reach the corrector
  assign w_accept    = w_sample && !r_alarm;
  // Second half of a pair that differs from the first: emit the first bit
  assign w_emit      = w_accept && r_pair_valid && (r_pair_bit != w_bit);
  assign w_byte_done = w_emit && (r_bit_cnt == 3'd7);
  assign w_wr_data   = {r_shift, r_pair_bit};

  // Two-flop synchroniser and decimation counter (holds while en=0)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b00;
      r_div  <= '0;
    end else begin
      r_sync <= {r_sync[0], raw_bit};
      if (en) r_div <= w_div_last ? '0 : r_div + 1'b1;
    end
  end

  // Repetition count: zero means no previous sample seen yet
  always_comb begin
    w_rct_next = c_rct_w'(1);
    if ((r_rct_cnt != '0) && (w_bit == r_prev)) begin
      w_rct_next = (r_rct_cnt == c_rct_w'(RCT_CUTOFF)) ? r_rct_cnt : r_rct_cnt + 1'b1;
    end
  end

  // Repetition-count state and sticky alarm
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev    <= 1'b0;
      r_rct_cnt <= '0;
      r_alarm   <= 1'b0;
    end else if (w_sample) begin
      r_prev    <= w_bit;
      r_rct_cnt <= w_rct_next;
      if (w_rct_next == c_rct_w'(RCT_CUTOFF)) r_alarm <= 1'b1;
    end
  end

  // von Neumann pairing and MSB-first packing; both freeze under alarm
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pair_valid <= 1'b0;
      r_pair_bit   <= 1'b0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
    end else if (w_accept) begin
      r_pair_valid <= !r_pair_valid;
      if (!r_pair_valid) r_pair_bit <= w_bit;
      if (w_emit) begin
        r_shift   <= {r_shift[5:0], r_pair_bit};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

  // Saturating count of completed bytes that found the FIFO full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_drop <= '0;
    else if (w_byte_done && w_full && (r_drop != '1)) r_drop <= r_drop + 1'b1;
  end

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_byte_done),
    .wr_data (w_wr_data),
    .rd_en   (w_rd_en),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty),
    .level   (fifo_level)
  );

  // TX state register plus the byte last handed to uart_tx
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ack_cnt <= '0;
      r_last    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_ack_cnt <= w_ack_cnt_next;
      if (w_rd_en) r_last <= w_rd_data;
    end
  end

  // TX next state: pop in IDLE, give busy a short window to rise, then drain
  always_comb begin
    w_state_next   = r_state;
    w_ack_cnt_next = r_ack_cnt;
    w_rd_en        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && !uart.busy) begin
          w_rd_en        = 1'b1;
          w_state_next   = ACK;
          w_ack_cnt_next = '0;
        end
      end
      ACK: begin
        if (uart.busy)                                   w_state_next = DRAIN;
        else if (r_ack_cnt == c_ack_w'(ACK_TIMEOUT - 1)) w_state_next = IDLE;
        else                                             w_ack_cnt_next = r_ack_cnt + 1'b1;
      end
      DRAIN: begin
        if (!uart.busy) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign uart.send = w_rd_en;
  assign uart.data = w_rd_en ? w_rd_data : r_last;
  assign drop_cnt  = r_drop;
  assign alarm     = r_alarm;
endmodule
`default_nettype wire

// File: tb/tb_trng_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_trng_conditioner
//  Description : Directed self-checking bench for trng_conditioner.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trng_conditioner;
  localparam int SAMPLE_DIV = 1;
  localparam int FIFO_DEPTH = 16;
  localparam int RCT_CUTOFF = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        raw_bit = 1'b0;
  logic [4:0]  fifo_level;
  logic [15:0] drop_cnt;
  logic        alarm;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] sent_q[$];
  int         sent_cyc[$];
  int         busy_viol = 0;
  bit         model_on = 1'b0;
  int         busy_left = 0;

  trng_conditioner_if u_if();

  trng_conditioner #(
    .SAMPLE_DIV (SAMPLE_DIV),
    .FIFO_DEPTH (FIFO_DEPTH),
    .RCT_CUTOFF (RCT_CUTOFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .raw_bit    (raw_bit),
    .uart       (u_if),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt),
    .alarm      (alarm)
  );

  always #5 clk = ~clk;

  // Mid-cycle monitor: log strobes, and optionally act as a uart_tx busy model
  always @(negedge clk) begin
    logic s;
    cyc++;
    s = (u_if.send === 1'b1);
    if (s) begin
      sent_q.push_back(u_if.data);
      sent_cyc.push_back(cyc);
      if (u_if.busy === 1'b1) busy_viol++;
    end
    if (model_on) begin
      if (busy_left > 0) begin
        u_if.busy = 1'b1;
        busy_left--;
      end else begin
        u_if.busy = 1'b0;
      end
      if (s) busy_left = 10;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    model_on = 1'b0;
    en = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_busy(input logic v);
    @(posedge clk);
    #2;
    u_if.busy = v;
  endtask

  task automatic push_sample(input logic b);
    @(negedge clk);
    raw_bit = b;
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      push_sample(v[i]);
      push_sample(!v[i]);
    end
  endtask

  task automatic wait_sends(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sent_q.size() >= n) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    u_if.busy = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm got %b want 0", alarm); end
    checks++; if (u_if.send !== 1'b0) begin errors++; $display("FAIL reset_send got %b want 0", u_if.send); end
    checks++; if (u_if.data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", u_if.data); end
    rst = 1'b0;
  endtask

  task automatic test_vn_pack();
    logic [1:0] pairs [12];
    pairs = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b01, 2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
    do_reset();
    u_if.busy = 1'b0;
    sent_q.delete(); sent_cyc.delete();
    foreach (pairs[i]) begin
      push_sample(pairs[i][1]);
      push_sample(pairs[i][0]);
    end
    wait_sends(1, 10);
    repeat (5) @(negedge clk);
    checks++; if (sent_q.size() != 1) begin errors++; $display("FAIL vn_strobes got %0d want 1", sent_q.size()); end
    checks++; if (sent_q.size() < 1 || sent_q[0] !== 8'hA5) begin errors++; $display("FAIL vn_byte got %h want a5", (sent_q.size() > 0) ? sent_q[0] : 8'hxx); end
    checks++; if (u_if.data !== 8'hA5) begin errors++; $display("FAIL vn_data_hold got %h want a5", u_if.data); end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL vn_level got %0d want 0", fifo_level); end
  endtask

  task automatic test_ack_timeout();
    logic [7:0] exp [4];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    set_busy(1'b1);
    foreach (exp[i]) push_byte(exp[i]);
    checks++; if (fifo_level !== 5'd4) begin errors++; $display("FAIL to_level got %0d want 4", fifo_level); end
    sent_q.delete(); sent_cyc.delete();
    set_busy(1'b0);
    wait_sends(4, 40);
    repeat (5) @(negedge clk);
    checks++; if (sent_q.size() != 4) begin errors++; $display("FAIL to_strobes got %0d want 4", sent_q.size()); end
    if (sent_q.size() == 4) begin
      foreach (exp[i]) begin
        checks++; if (sent_q[i] !== exp[i]) begin errors++; $display("FAIL to_data%0d got %h want %h", i, sent_q[i], exp[i]); end
      end
      for (int i = 1; i < 4; i++) begin
        checks++; if (sent_cyc[i] - sent_cyc[i-1] != 3) begin errors++; $display("FAIL to_spacing%0d got %0d want 3", i, sent_cyc[i] - sent_cyc[i-1]); end
      end
    end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL to_empty got %0d want 0", fifo_level); end
  endtask

  task automatic test_busy_model();
    do_reset();
    set_busy(1'b1);
    push_byte(8'h5A);
    push_byte(8'hC3);
    sent_q.delete(); sent_cyc.delete();
    busy_viol = 0;
    busy_left = 0;
    @(posedge clk);
    #2;
    u_if.busy = 1'b0;
    model_on = 1'b1;
    wait_sends(2, 60);
    repeat (15) @(negedge clk);
    model_on = 1'b0;
    u_if.busy = 1'b0;
    checks++; if (sent_q.size() != 2) begin errors++; $display("FAIL bm_strobes got %0d want 2", sent_q.size()); end
    if (sent_q.size() == 2) begin
      checks++; if (sent_q[0] !== 8'h5A || sent_q[1] !== 8'hC3) begin errors++; $display("FAIL bm_data got %h %h want 5a c3", sent_q[0], sent_q[1]); end
      checks++; if (sent_cyc[1] - sent_cyc[0] != 12) begin errors++; $display("FAIL bm_spacing got %0d want 12", sent_cyc[1] - sent_cyc[0]); end
    end
    checks++; if (busy_viol != 0) begin errors++; $display("FAIL bm_send_while_busy got %0d want 0", busy_viol); end
  endtask

  task automatic test_fifo_full();
    logic [7:0] v;
    do_reset();
    set_busy(1'b1);
    for (int i = 0; i < 18; i++) begin
      v = 8'(i * 7 + 3);
      push_byte(v);
    end
    checks++; if (fifo_level !== 5'd16) begin errors++; $display("FAIL ff_level got %0d want 16", fifo_level); end
    checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL ff_drop got %0d want 2", drop_cnt); end
    sent_q.delete(); sent_cyc.delete();
    set_busy(1'b0);
    wait_sends(16, 100);
    repeat (5) @(negedge clk);
    checks++; if (sent_q.size() != 16) begin errors++; $display("FAIL ff_strobes got %0d want 16", sent_q.size()); end
    if (sent_q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        v = 8'(i * 7 + 3);
        checks++; if (sent_q[i] !== v) begin errors++; $display("FAIL ff_data%0d got %h want %h", i, sent_q[i], v); end
      end
    end
    checks++; if (fifo_level !== 5'd0) begin errors++; $display("FAIL ff_drained got %0d want 0", fifo_level); end
  endtask

  task automatic test_alarm();
    do_reset();
    u_if.busy = 1'b0;
    sent_q.delete(); sent_cyc.delete();
    for (int i = 0; i < 31; i++) push_sample(1'b1);
    checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL rct_31 got %b want 0", alarm); end
    push_sample(1'b1);
    checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL rct_32 got %b want 1", alarm); end
    push_byte(8'hA5);
    repeat (5) @(negedge clk);
    checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL rct_sticky got %b want 1", alarm); end
    checks++; if (sent_q.size() != 0 || fifo_level !== 5'd0) begin errors++; $display("FAIL rct_frozen got %0d strobes level %0d want 0 0", sent_q.size(), fifo_level); end
    do_reset();
    checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL rct_cleared got %b want 0", alarm); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    u_if.busy = 1'b0;
    push_byte(8'h3C);
    repeat (5) @(negedge clk);
    checks++; if (u_if.data !== 8'h3C) begin errors++; $display("FAIL rm_hold got %h want 3c", u_if.data); end
    set_busy(1'b1);
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    push_sample(1'b1); push_sample(1'b0);
    push_sample(1'b1); push_sample(1'b0);
    push_sample(1'b1); push_sample(1'b0);
    push_sample(1'b1); push_sample(1'b0);
    checks++; if (fifo_level !== 5'd3) begin errors++; $display("FAIL rm_level_pre got %0d want 3", fifo_level); end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (fifo_level !== 5'd0 || u_if.send !== 1'b0 || u_if.data !== 8'h00 || drop_cnt !== 16'd0 || alarm !== 1'b0)
      begin errors++; $display("FAIL rm_async got level %0d send %b data %h drop %0d alarm %b want all 0", fifo_level, u_if.send, u_if.data, drop_cnt, alarm); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    u_if.busy = 1'b0;
    sent_q.delete(); sent_cyc.delete();
    push_byte(8'h5A);
    wait_sends(1, 10);
    repeat (3) @(negedge clk);
    checks++; if (sent_q.size() != 1 || sent_q[0] !== 8'h5A) begin errors++; $display("FAIL rm_post got %0d strobes first %h want 1 5a", sent_q.size(), (sent_q.size() > 0) ? sent_q[0] : 8'hxx); end
  endtask

  initial begin
    u_if.busy = 1'b0;
    test_reset();
    test_vn_pack();
    test_ack_timeout();
    test_busy_model();
    test_fifo_full();
    test_alarm();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
